cel_cfg_loader: RTL

- Configuration writer for the `cel` logic-cell array. `cel` consumes a 31-bit `ctr` word; this block produces one `ctr` word per cell.
- Receives a serial configuration frame, assembles it into a shadow register and checks the header and parity.
- On success, atomically commits all NCEL words to `ctr_bus`, which drives the cells' `ctr` inputs.
- A corrupt or stalled frame never reaches the cells: the previously committed configuration stays in place.

---
 rtl/cel_cfg_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/cel_cfg_loader.sv
// cel_cfg_loader: assembles a serial config frame, checks header/parity, atomically commits cel ctr words
module cel_cfg_loader #(
  parameter int NCEL = 4,
  parameter int CW   = 31,
  parameter int TMO  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sdi,
  input  logic                 sdi_vld,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [NCEL*CW-1:0]   ctr_bus
);
  localparam int PW = NCEL * CW;
  localparam int BW = $clog2(PW + 1);
  localparam int IW = $clog2(TMO + 1);
  localparam logic [BW-1:0] HLAST = BW'(7);
  localparam logic [BW-1:0] PLAST = BW'(PW - 1);
  localparam logic [IW-1:0] ILIM  = IW'(TMO);
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_PAR} state_t;
  state_t          r_state, w_state;
  logic [7:0]      r_hdr;
  logic [PW-1:0]   r_shadow, r_ctr;
  logic            r_par, r_done, r_err;
  logic [1:0]      r_code, w_code;
  logic [BW-1:0]   r_bcnt;
  logic [IW-1:0]   r_icnt, w_icnt_inc;
  logic            w_acc, w_tmo, w_commit, w_done, w_err;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_code;
  assign ctr_bus    = r_ctr;
  assign w_acc      = sdi_vld && busy;
  assign w_icnt_inc = (r_icnt == ILIM) ? r_icnt : r_icnt + 1'b1;
  assign w_tmo      = busy && !sdi_vld && (w_icnt_inc == ILIM);
  assign w_commit   = (r_state == S_PAR) && w_acc && !(r_par ^ sdi);
  // next state, result pulses and rejection code
  always_comb begin
    w_state = r_state;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_code  = r_code;
    if (r_state == S_IDLE) begin
      if (start) begin
        w_state = S_HDR;
        w_code  = 2'd0;
      end
    end else if (w_tmo) begin
      w_state = S_IDLE;
      w_err   = 1'b1;
      w_code  = 2'd3;
    end else if (w_acc) begin
      case (r_state)
        S_HDR: if (r_bcnt == HLAST) begin
          w_state = ({r_hdr[6:0], sdi} == 8'hA5) ? S_PAY : S_IDLE;
          w_err   = ({r_hdr[6:0], sdi} != 8'hA5);
          w_code  = ({r_hdr[6:0], sdi} != 8'hA5) ? 2'd1 : r_code;
        end
        S_PAY: w_state = (r_bcnt == PLAST) ? S_PAR : S_PAY;
        S_PAR: begin
          w_state = S_IDLE;
          w_done  = w_commit;
          w_err   = !w_commit;
          w_code  = w_commit ? r_code : 2'd2;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end
  // state register and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'd0;
    end else begin
      r_state <= w_state;
      r_done  <= w_done;
      r_err   <= w_err;
      r_code  <= w_code;
    end
  end
  // frame datapath: counters, header/shadow shifters, running parity and committed config
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcnt   <= '0;
      r_icnt   <= '0;
      r_hdr    <= '0;
      r_shadow <= '0;
      r_par    <= 1'b0;
      r_ctr    <= '0;
    end else begin
      r_bcnt   <= (!busy || (w_acc && r_state == S_HDR && r_bcnt == HLAST)) ? '0 : w_acc ? r_bcnt + 1'b1 : r_bcnt;
      r_icnt   <= (!busy || sdi_vld) ? '0 : w_icnt_inc;
      r_hdr    <= (r_state == S_HDR && w_acc) ? {r_hdr[6:0], sdi} : r_hdr;
      r_shadow <= (r_state == S_PAY && w_acc) ? {r_shadow[PW-2:0], sdi} : r_shadow;
      r_par    <= !busy ? 1'b0 : (r_state == S_PAY && w_acc) ? r_par ^ sdi : r_par;
      r_ctr    <= w_commit ? r_shadow : r_ctr;
    end
  end
endmodule
